mpram_wr_sched: RTL

//  Write scheduler that sits directly upstream of the multiport RAM write ports (wra/wrb).

---
 rtl/mpram_wr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mpram_wr_sched.sv
// Write scheduler feeding the two RAM write ports: one request FIFO per stream,
// registered dispatch, and fair alternation when both heads target the same address.
module mpram_wr_sched #(
    parameter int P_MEM_DEPTH  = 2048,
    parameter int P_MEM_WIDTH  = 32,
    parameter int P_FIFO_DEPTH = 4,
    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH),
    localparam int LP_CNT_W       = $clog2(P_FIFO_DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LP_INDEX_WIDTH-1:0] req0_addr_i,
    input  logic [P_MEM_WIDTH-1:0]    req0_data_i,
    input  logic                      req0_valid_i,
    output logic                      req0_ready_o,
    input  logic [LP_INDEX_WIDTH-1:0] req1_addr_i,
    input  logic [P_MEM_WIDTH-1:0]    req1_data_i,
    input  logic                      req1_valid_i,
    output logic                      req1_ready_o,
    output logic [LP_INDEX_WIDTH-1:0] wra_addr_o,
    output logic [P_MEM_WIDTH-1:0]    wra_data_o,
    output logic                      wra_valid_o,
    output logic [LP_INDEX_WIDTH-1:0] wrb_addr_o,
    output logic [P_MEM_WIDTH-1:0]    wrb_data_o,
    output logic                      wrb_valid_o,
    output logic [LP_CNT_W-1:0]       occ0_o,
    output logic [LP_CNT_W-1:0]       occ1_o,
    output logic [15:0]               collision_cnt_o,
    output logic                      idle_o
);
    localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);

    logic [LP_INDEX_WIDTH-1:0] addr_q [2][P_FIFO_DEPTH];
    logic [LP_INDEX_WIDTH-1:0] addr_d [2][P_FIFO_DEPTH];
    logic [P_MEM_WIDTH-1:0]    data_q [2][P_FIFO_DEPTH];
    logic [P_MEM_WIDTH-1:0]    data_d [2][P_FIFO_DEPTH];
    logic [LP_PTR_W-1:0]       wp_q [2], wp_d [2], rp_q [2], rp_d [2];
    logic [LP_CNT_W-1:0]       occ_q [2], occ_d [2];
    logic                      last_winner_q, last_winner_d;
    logic [15:0]               coll_cnt_q, coll_cnt_d;
    logic [LP_INDEX_WIDTH-1:0] out_addr_q [2], out_addr_d [2];
    logic [P_MEM_WIDTH-1:0]    out_data_q [2], out_data_d [2];
    logic                      out_valid_q [2], out_valid_d [2];

    logic [LP_INDEX_WIDTH-1:0] in_addr [2];
    logic [P_MEM_WIDTH-1:0]    in_data [2];
    logic                      in_valid [2];
    logic                      ready [2], push [2], pop [2], head [2];
    logic [LP_INDEX_WIDTH-1:0] head_addr [2];
    logic                      coll, winner;

    always_comb begin
        in_addr[0]  = req0_addr_i;
        in_addr[1]  = req1_addr_i;
        in_data[0]  = req0_data_i;
        in_data[1]  = req1_data_i;
        in_valid[0] = req0_valid_i;
        in_valid[1] = req1_valid_i;
        for (int s = 0; s < 2; s++) begin
            ready[s]     = (occ_q[s] != LP_CNT_W'(P_FIFO_DEPTH));
            push[s]      = in_valid[s] & ready[s];
            head[s]      = (occ_q[s] != '0);
            head_addr[s] = addr_q[s][rp_q[s]];
        end
        coll   = head[0] & head[1] & (head_addr[0] == head_addr[1]);
        // winner 0 = stream 0; on a collision only the winner pops
        winner = ~last_winner_q;
        pop[0] = head[0] & (~coll | ~winner);
        pop[1] = head[1] & (~coll | winner);

        addr_d        = addr_q;
        data_d        = data_q;
        last_winner_d = last_winner_q;
        coll_cnt_d    = coll_cnt_q;
        if (coll) begin
            last_winner_d = winner;
            if (coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
        end
        for (int s = 0; s < 2; s++) begin
            wp_d[s]        = wp_q[s];
            rp_d[s]        = rp_q[s];
            occ_d[s]       = occ_q[s] + LP_CNT_W'(push[s]) - LP_CNT_W'(pop[s]);
            out_valid_d[s] = pop[s];
            out_addr_d[s]  = out_addr_q[s];
            out_data_d[s]  = out_data_q[s];
            if (push[s]) begin
                addr_d[s][wp_q[s]] = in_addr[s];
                data_d[s][wp_q[s]] = in_data[s];
                wp_d[s]            = wp_q[s] + LP_PTR_W'(1);
            end
            if (pop[s]) begin
                out_addr_d[s] = head_addr[s];
                out_data_d[s] = data_q[s][rp_q[s]];
                rp_d[s]       = rp_q[s] + LP_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q        <= '{default: '{default: '0}};
            data_q        <= '{default: '{default: '0}};
            wp_q          <= '{default: '0};
            rp_q          <= '{default: '0};
            occ_q         <= '{default: '0};
            last_winner_q <= 1'b1;
            coll_cnt_q    <= '0;
            out_addr_q    <= '{default: '0};
            out_data_q    <= '{default: '0};
            out_valid_q   <= '{default: 1'b0};
        end else begin
            addr_q        <= addr_d;
            data_q        <= data_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            occ_q         <= occ_d;
            last_winner_q <= last_winner_d;
            coll_cnt_q    <= coll_cnt_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign req0_ready_o    = ready[0];
    assign req1_ready_o    = ready[1];
    assign wra_addr_o      = out_addr_q[0];
    assign wra_data_o      = out_data_q[0];
    assign wra_valid_o     = out_valid_q[0];
    assign wrb_addr_o      = out_addr_q[1];
    assign wrb_data_o      = out_data_q[1];
    assign wrb_valid_o     = out_valid_q[1];
    assign occ0_o          = occ_q[0];
    assign occ1_o          = occ_q[1];
    assign collision_cnt_o = coll_cnt_q;
    assign idle_o          = (occ_q[0] == '0) & (occ_q[1] == '0) & ~out_valid_q[0] & ~out_valid_q[1];
endmodule
